// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-bus types.
//   mem_h2d_t     host-to-device request (req, we, addr, data, mask)
//   mem_d2h_t     device-to-host response (gnt, valid, data, error)
//   mem_host_id_t index of a host port on an arbiter (up to 8 hosts)
//   arb_state_e   arbiter state encoding
package mem_pkg;

    localparam int MEM_AW       = 32;
    localparam int MEM_DW       = 32;
    localparam int MEM_MW       = MEM_DW / 8;
    localparam int MEM_HOST_IDW = 3;

    typedef logic [MEM_HOST_IDW-1:0] mem_host_id_t;

    typedef struct packed {
        logic              req;
        logic              we;
        logic [MEM_AW-1:0] addr;
        logic [MEM_DW-1:0] data;
        logic [MEM_MW-1:0] mask;
    } mem_h2d_t;

    typedef struct packed {
        logic              gnt;
        logic              valid;
        logic [MEM_DW-1:0] data;
        logic [1:0]        error;
    } mem_d2h_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/mem_id_fifo.sv
// mem_id_fifo: small FIFO of host ids, one entry per accepted request that
// still awaits its in-order response.
//   clk_i, rst_ni  clock, synchronous active-low reset (empties the FIFO)
//   push_i, data_i write one id at the tail
//   pop_i          drop the head entry
//   head_o         id at the head (meaningful when count_o != 0)
//   count_o        number of stored entries, 0..DEPTH
module mem_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;

    // Pointers wrap naturally because DEPTH is a power of two; the separate
    // count distinguishes full from empty when the pointers are equal.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop_i)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr_ptr] <= data_i;
    end

    assign head_o  = r_mem[r_rd_ptr];
    assign count_o = r_count;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter merging NUM_HOSTS request ports onto one
// memory device and routing the in-order responses back to their hosts.
//   clk_i, rst_ni   clock, synchronous active-low reset
//   host_req_i[i]   per-host request
//   host_rsp_o[i]   per-host gnt/valid; data/error broadcast to all hosts
//   dev_req_o       merged request to the device
//   dev_rsp_i       device gnt, in-order valid, data, error
//   outstanding_o   accepted requests still awaiting a response
//   unexp_rsp_o     sticky: a response arrived with nothing outstanding
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_HOSTS       = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  mem_h2d_t                         host_req_i [NUM_HOSTS],
    output mem_d2h_t                         host_rsp_o [NUM_HOSTS],
    output mem_h2d_t                         dev_req_o,
    input  mem_d2h_t                         dev_rsp_i,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
    output logic                             unexp_rsp_o
);

    localparam int CNTW = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_e   r_state;
    arb_state_e   w_state_nxt;
    mem_host_id_t r_lock_id;
    mem_host_id_t r_last_grant;
    mem_host_id_t w_winner;
    mem_host_id_t w_sel;
    mem_host_id_t w_head;
    logic         w_any_req;
    logic         w_dev_req;
    logic         w_xfer;
    logic         w_pop;
    logic         w_full;
    logic         w_empty;
    logic         r_unexp;
    logic [CNTW-1:0] w_count;
    int           w_best;
    int           w_dist;

    assign w_full  = (w_count == CNTW'(MAX_OUTSTANDING));
    assign w_empty = (w_count == '0);

    // Round robin: each host's distance is how many places it sits after the
    // last granted host; the requesting host with the smallest distance wins.
    always_comb begin
        w_winner  = '0;
        w_any_req = 1'b0;
        w_best    = NUM_HOSTS;
        w_dist    = 0;
        for (int i = 0; i < NUM_HOSTS; i++) begin
            w_dist = (i + 2 * NUM_HOSTS - int'(r_last_grant) - 1) % NUM_HOSTS;
            if (host_req_i[i].req && (w_dist < w_best)) begin
                w_best    = w_dist;
                w_winner  = mem_host_id_t'(i);
                w_any_req = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel       = r_lock_id;
        w_dev_req   = 1'b0;
        case (r_state)
            ARB_IDLE: begin
                // A full FIFO blocks new arbitration even if a pop is pending.
                if (w_any_req && !w_full) begin
                    w_sel     = w_winner;
                    w_dev_req = 1'b1;
                    if (!dev_rsp_i.gnt) w_state_nxt = ARB_LOCKED;
                end
            end
            ARB_LOCKED: begin
                w_dev_req = 1'b1;
                if (dev_rsp_i.gnt) w_state_nxt = ARB_IDLE;
            end
        endcase
        if (!rst_ni) w_dev_req = 1'b0;
    end

    assign w_xfer = w_dev_req && dev_rsp_i.gnt;
    assign w_pop  = rst_ni && dev_rsp_i.valid && !w_empty;

    always_comb begin
        dev_req_o = '0;
        if (w_dev_req) begin
            for (int i = 0; i < NUM_HOSTS; i++) begin
                if (w_sel == mem_host_id_t'(i)) dev_req_o = host_req_i[i];
            end
            dev_req_o.req = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_HOSTS; i++) begin
            host_rsp_o[i].gnt   = w_xfer && (w_sel == mem_host_id_t'(i));
            host_rsp_o[i].valid = w_pop && (w_head == mem_host_id_t'(i));
            host_rsp_o[i].data  = dev_rsp_i.data;
            host_rsp_o[i].error = dev_rsp_i.error;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= mem_host_id_t'(NUM_HOSTS - 1);
            r_unexp      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_xfer) r_last_grant <= w_sel;
            if (dev_rsp_i.valid && w_empty) r_unexp <= 1'b1;
        end
    end

    // The winner is captured every IDLE cycle; it is only used once the
    // request actually stalls and the state moves to LOCKED.
    always_ff @(posedge clk_i) begin
        if (r_state == ARB_IDLE) r_lock_id <= w_winner;
    end

    mem_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (MEM_HOST_IDW)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_xfer),
        .data_i  (w_sel),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .count_o (w_count)
    );

    assign outstanding_o = w_count;
    assign unexp_rsp_o   = r_unexp;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import mem_pkg::*;

    localparam int NH   = 2;
    localparam int MAXO = 4;

    logic     clk = 1'b0;
    logic     rst_n;
    mem_h2d_t host_req [NH];
    mem_d2h_t host_rsp [NH];
    mem_h2d_t dev_req;
    mem_d2h_t dev_rsp;
    logic [2:0] outstanding;
    logic     unexp;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of host ids awaiting responses, pending locked host.
    int q[$];
    int lock   = -1;
    int last   = NH - 1;
    bit m_unexp = 1'b0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .NUM_HOSTS       (NH),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .host_req_i    (host_req),
        .host_rsp_o    (host_rsp),
        .dev_req_o     (dev_req),
        .dev_rsp_i     (dev_rsp),
        .outstanding_o (outstanding),
        .unexp_rsp_o   (unexp)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int h = 0; h < NH; h++) host_req[h] = '0;
        dev_rsp = '0;
    endtask

    // One clock cycle: compare outputs with the model at the falling edge,
    // then advance the model across the rising edge.
    task automatic step();
        int owner;
        bit xfer;
        bit pop;
        owner = -1;
        xfer  = 1'b0;
        pop   = 1'b0;
        @(negedge clk);
        if (!rst_n) begin
            check_val("rst_dev_req", dev_req.req, 0);
            for (int h = 0; h < NH; h++) begin
                check_val($sformatf("rst_gnt%0d", h), host_rsp[h].gnt, 0);
                check_val($sformatf("rst_valid%0d", h), host_rsp[h].valid, 0);
            end
        end else begin
            if (lock >= 0) owner = lock;
            else if (q.size() < MAXO) begin
                for (int k = 1; k <= NH; k++) begin
                    int hh;
                    hh = (last + k) % NH;
                    if (host_req[hh].req) begin
                        owner = hh;
                        break;
                    end
                end
            end
            check_val("dev_req", dev_req.req, owner >= 0);
            if (owner >= 0) begin
                check_val("dev_addr", dev_req.addr, host_req[owner].addr);
                check_val("dev_data", dev_req.data, host_req[owner].data);
            end
            xfer = (owner >= 0) && dev_rsp.gnt;
            pop  = dev_rsp.valid && (q.size() > 0);
            for (int h = 0; h < NH; h++) begin
                check_val($sformatf("gnt%0d", h), host_rsp[h].gnt, xfer && (h == owner));
                check_val($sformatf("valid%0d", h), host_rsp[h].valid, pop && (h == q[0]));
                if (pop) check_val($sformatf("rdata%0d", h), host_rsp[h].data, dev_rsp.data);
            end
        end
        check_val("outstanding", outstanding, q.size());
        check_val("unexp", unexp, m_unexp);
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            lock    = -1;
            last    = NH - 1;
            m_unexp = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            else if (dev_rsp.valid) m_unexp = 1'b1;
            if (xfer) begin
                q.push_back(owner);
                last = owner;
                lock = -1;
            end else if (owner >= 0) begin
                lock = owner;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step();
        rst_n = 1'b1;

        // Two hosts always requesting, device always granting, latency-2 responses.
        host_req[0].req  = 1'b1;
        host_req[0].addr = 32'h0000_1000;
        host_req[1].req  = 1'b1;
        host_req[1].addr = 32'h0000_2000;
        dev_rsp.gnt      = 1'b1;
        for (int c = 0; c < 8; c++) begin
            dev_rsp.valid = (c >= 2);
            dev_rsp.data  = $urandom;
            #1;
            check_val("alt_gnt0", host_rsp[0].gnt, (c % 2) == 0);
            check_val("alt_gnt1", host_rsp[1].gnt, (c % 2) == 1);
            if (c >= 2) check_val("lat2_valid", host_rsp[(c - 2) % 2].valid, 1);
            step();
        end

        // Host 1 stalls on the device while host 0 joins; lock must hold.
        do_reset();
        host_req[1].addr = 32'hA1A1_0001;
        host_req[1].data = 32'h1111_2222;
        host_req[0].addr = 32'hA0A0_0000;
        for (int c = 1; c <= 5; c++) begin
            host_req[1].req = (c <= 4);
            host_req[0].req = (c >= 2);
            dev_rsp.gnt     = (c >= 4);
            #1;
            if (c <= 3) begin
                check_val("lock_addr", dev_req.addr, 32'hA1A1_0001);
                check_val("lock_req", dev_req.req, 1);
            end
            if (c == 4) check_val("lock_gnt1", host_rsp[1].gnt, 1);
            if (c == 5) check_val("next_gnt0", host_rsp[0].gnt, 1);
            step();
        end

        // Fill to MAX_OUTSTANDING, then one response re-opens arbitration.
        do_reset();
        host_req[0].req = 1'b1;
        dev_rsp.gnt     = 1'b1;
        for (int c = 0; c < 4; c++) step();
        dev_rsp.valid = 1'b1;
        #1;
        check_val("full_cnt", outstanding, 4);
        check_val("full_noreq", dev_req.req, 0);
        step();
        dev_rsp.valid = 1'b0;
        #1;
        check_val("reopen_req", dev_req.req, 1);
        check_val("reopen_cnt", outstanding, 3);
        step();

        // Simultaneous push and pop at count 2 keeps count and order.
        do_reset();
        dev_rsp.gnt     = 1'b1;
        host_req[1].req = 1'b1;
        step();
        host_req[1].req = 1'b0;
        host_req[0].req = 1'b1;
        step();
        host_req[0].req = 1'b0;
        host_req[1].req = 1'b1;
        dev_rsp.valid   = 1'b1;
        #1;
        check_val("pp_cnt_before", outstanding, 2);
        check_val("pp_valid1", host_rsp[1].valid, 1);
        step();
        host_req[1].req = 1'b0;
        #1;
        check_val("pp_cnt_after", outstanding, 2);
        check_val("pp_valid0", host_rsp[0].valid, 1);
        step();
        step();
        dev_rsp.valid = 1'b0;
        step();

        // Response with nothing outstanding.
        do_reset();
        dev_rsp.valid = 1'b1;
        dev_rsp.error = 2'b10;
        #1;
        check_val("unexp_v0", host_rsp[0].valid, 0);
        check_val("unexp_v1", host_rsp[1].valid, 0);
        step();
        dev_rsp = '0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_val("unexp_sticky", unexp, 1);
            step();
        end
        do_reset();
        #1;
        check_val("unexp_cleared", unexp, 0);

        // Reset with requests outstanding discards them.
        host_req[0].req = 1'b1;
        host_req[1].req = 1'b1;
        dev_rsp.gnt     = 1'b1;
        for (int c = 0; c < 3; c++) step();
        #1;
        check_val("pre_rst_cnt", outstanding, 3);
        do_reset();
        #1;
        check_val("post_rst_cnt", outstanding, 0);
        dev_rsp.valid = 1'b1;
        step();
        dev_rsp.valid = 1'b0;
        #1;
        check_val("late_unexp", unexp, 1);
        host_req[0].req = 1'b1;
        host_req[1].req = 1'b1;
        dev_rsp.gnt     = 1'b1;
        #1;
        check_val("post_rst_prio", host_rsp[0].gnt, 1);
        step();

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst_n = ($urandom % 250) != 0;
            for (int h = 0; h < NH; h++) begin
                if (h == lock) begin
                    host_req[h].req = 1'b1;
                end else begin
                    host_req[h].req  = ($urandom % 3) != 0;
                    host_req[h].we   = 1'($urandom);
                    host_req[h].addr = $urandom;
                    host_req[h].data = $urandom;
                    host_req[h].mask = 4'($urandom);
                end
            end
            dev_rsp.gnt   = ($urandom % 3) != 0;
            dev_rsp.valid = (q.size() > 0) ? (($urandom % 5) < 2) : (($urandom % 40) == 0);
            dev_rsp.data  = $urandom;
            dev_rsp.error = 2'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_HOSTS, default 2, number of host ports (range 2..8).
REQ-002 Parameter MAX_OUTSTANDING, default 4, max accepted-but-unanswered requests (power of two, 2..16).
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 host_req_i  input  NUM_HOSTS x mem_h2d_t  per-host request (req, we, addr, data, mask).
REQ-006 host_rsp_o  output  NUM_HOSTS x mem_d2h_t  per-host gnt, valid, data, error.
REQ-007 dev_req_o  output  mem_h2d_t  merged request to the single memory device.
REQ-008 dev_rsp_i  input  mem_d2h_t  device gnt, in-order valid, data, error.
REQ-009 outstanding_o  output  $clog2(MAX_OUTSTANDING)+1  number of requests awaiting response.
REQ-010 unexp_rsp_o  output  1  sticky flag: dev_rsp_i.valid seen with zero outstanding.

Function
REQ-011 Transfer on host i: host_req_i[i].req and host_rsp_o[i].gnt high in the same cycle; the device accepts in-order, one response per accepted request, at least one cycle after gnt.
REQ-012 Arbiter states: IDLE (no request driven) and LOCKED (dev_req_o.req high, awaiting dev gnt).
REQ-013 In IDLE, with any host req high and outstanding_o < MAX_OUTSTANDING: select round-robin winner starting from the host after last_grant; drive dev_req_o from winner combinationally in the same cycle.
REQ-014 If dev_rsp_i.gnt is high in that same cycle, the transfer completes and the state stays IDLE; otherwise the winner index is registered and the state moves to LOCKED.
REQ-015 In LOCKED, dev_req_o follows only the locked host, regardless of other requests; on dev gnt return to IDLE.
REQ-016 The locked host shall not deassert req before gnt; violating this is out of scope.
REQ-017 host_rsp_o[i].gnt = dev_rsp_i.gnt AND host i selected AND dev_req_o.req; every other host's gnt is 0.
REQ-018 last_grant shall update to the winner only on a completed transfer; reset value NUM_HOSTS-1, so host 0 has first priority.
REQ-019 On every completed transfer, push the winner index into the ID FIFO (depth MAX_OUTSTANDING).
REQ-020 When outstanding_o == MAX_OUTSTANDING, dev_req_o.req shall be 0 in IDLE (no new arbitration), even if a response pops in the same cycle; an already-LOCKED request still completes.
REQ-021 On dev_rsp_i.valid with FIFO non-empty: host_rsp_o[head].valid = 1, then pop; all other hosts' valid = 0.
REQ-022 dev_rsp_i.data and .error are broadcast to all host_rsp_o; only valid qualifies them.
REQ-023 Simultaneous push and pop shall leave outstanding_o unchanged and preserve order.
REQ-024 dev_rsp_i.valid with FIFO empty: no host valid, no pop, set unexp_rsp_o (cleared only by reset).
REQ-025 FIFO pointers wrap modulo MAX_OUTSTANDING; the count is held separately so full and empty are distinct.

Reset
REQ-026 Under rst_ni low at a clock edge: state IDLE, FIFO empty, outstanding_o 0, unexp_rsp_o 0, last_grant NUM_HOSTS-1.
REQ-027 During reset all host gnt/valid and dev_req_o.req shall be 0.
REQ-028 Reset mid-transfer shall discard outstanding IDs; responses arriving after reset shall set unexp_rsp_o.

Structure
REQ-029 mem_pkg shall gain MEM_HOST_IDW and a host-id typedef; mem_h2d_t and mem_d2h_t are reused unchanged.
REQ-030 The ID FIFO shall be the sub-module mem_id_fifo (params DEPTH, WIDTH; push, pop, head, count).
REQ-031 Target size: 120-400 lines RTL total.

Verification
REQ-032 Hosts 0 and 1 request constantly; dev gnt is always 1 -> grants alternate 0,1,0,1; responses with latency 2 are routed to the matching hosts.
REQ-033 Host 1 requests; dev gnt is low for 3 cycles, and host 0 raises req in cycle 2 -> dev_req_o holds host 1's addr/data stably; host 1 gnt is seen in cycle 4; host 0 is served next.
REQ-034 MAX_OUTSTANDING=4; 4 grants with no responses -> outstanding_o=4 and dev_req_o.req=0; one response -> req is reasserted the next cycle.
REQ-035 Push and pop in the same cycle at count 2 -> count stays 2; response order is host 1, then host 0, matching the grant order.
REQ-036 dev_rsp_i.valid with error=2'b10 and empty FIFO -> no host valid; unexp_rsp_o=1 until rst_ni low.
REQ-037 rst_ni low with 3 outstanding, then released -> outstanding_o=0, host 0 has priority, and a late response sets unexp_rsp_o.
